axi_sram_slave: RTL and testbench
=================================

// Module: axi_sram_slave
// PURPOSE
//  AXI4-style burst SRAM slave directly downstream of the core's bus arbiter; serves IF fetches and
//  MEM loads/stores. Independent read (AR/R) and write (AW/W/B) FSMs, byte-strobed writes, a
//  configurable read latency and DECERR on out-of-range addresses.
// PARAMETERS
//  ADDR_W     32            address width
//  DATA_W     64            data width; beat = 8 bytes
//  DEPTH      4096          memory depth in DATA_W words
//  BASE_ADDR  32'h8000_0000 byte address of word 0
//  RD_LAT     1             wait cycles between AR handshake and first R beat (>=0)
// PORTS
//  clk      in   1      clock
//  rst      in   1      sync reset, active-high
//  araddr   in   ADDR_W read burst start byte address
//  arvalid  in   1      read address valid
//  arburst  in   2      00 FIXED, 01 INCR, 10 WRAP (unsupported), 11 reserved
//  arlen    in   8      beats-1
//  arsize   in   3      bytes/beat = 2^arsize (<=3)
//  arready  out  1      read address accepted
//  rdata    out  DATA_W read data
//  rresp    out  2      00 OKAY, 10 SLVERR, 11 DECERR
//  rvalid   out  1      read beat valid
//  rlast    out  1      final beat of burst
//  rready   in   1      master accepts beat
//  awaddr   in   ADDR_W write burst start byte address
//  awvalid  in   1      write address valid
//  awburst  in   2      as arburst
//  awlen    in   8      beats-1
//  awready  out  1      write address accepted
//  wdata    in   DATA_W write data
//  wstrb    in   8      byte enables, bit i -> wdata[8i+7:8i]
//  wlast    in   1      master's final-beat marker
//  wvalid   in   1      write beat valid
//  wready   out  1      slave accepts write beat
//  bresp    out  2      write response
//  bvalid   out  1      write response valid
//  bready   in   1      master accepts response
// BEHAVIOUR
//  Reset: arready=awready=wready=rvalid=rlast=bvalid=0, rdata=0, rresp=bresp=00; both FSMs idle;
//   arready/awready rise the cycle after rst deasserts. Memory array not reset. Reset mid-burst aborts
//   immediately; beats already written remain.
//  Word index = (addr-BASE_ADDR)>>3; in-range iff BASE_ADDR <= addr < BASE_ADDR+8*DEPTH.
//  Read FSM R_IDLE->R_WAIT->R_DATA. R_IDLE: arready=1; arvalid&arready latches addr/len/size/burst,
//   arready=0 next cycle. R_WAIT counts RD_LAT cycles (skipped if RD_LAT=0); first rvalid exactly
//   RD_LAT+1 cycles after AR handshake. R_DATA: rvalid=1; rdata/rresp/rlast held stable while !rready;
//   on rvalid&rready advance beat; rlast=1 iff beat==arlen. After final handshake -> R_IDLE.
//  Address step: INCR += 2^size (wraps within ADDR_W); FIXED no change; WRAP/11 treated as INCR with
//   resp SLVERR on every beat. Per beat: out-of-range -> rresp=DECERR, rdata=0; else full word.
//  Write FSM W_IDLE->W_DATA->W_RESP. W_IDLE: awready=1; AW handshake latches addr/len/burst.
//   W_DATA: wready=1; each wvalid&wready writes bytes with wstrb=1 (out-of-range: dropped, error
//   flagged); address steps by 8 (INCR) or 0 (FIXED). Burst ends on beat==awlen regardless of wlast;
//   wlast mismatch (early or missing) -> SLVERR. W_RESP: bvalid=1, bresp = worst of DECERR>SLVERR>OKAY
//   seen in burst; held until bready, then W_IDLE.
//  Channels fully concurrent. Same-cycle R-read and W-write of one word: read returns pre-write data.
//  Single outstanding transaction per channel; no AR/AW accepted until previous burst completes.
// TESTING
//  1 Single read: mem[0]=64'h1122334455667788, AR 0x80000000 len0 size3 INCR, rready=1 -> rvalid
//    at cycle RD_LAT+1 after AR, rdata=64'h1122334455667788, rlast=1, rresp=00.
//  2 Burst read INCR len3 from 0x80000010, rready low 2 cycles on beat1 -> beats mem[2..5] in order,
//    beat1 held stable during stall, rlast only on 4th beat, arready=1 one cycle after final beat.
//  3 Write 0x80000020 len0 wdata=64'hAAAA_BBBB_CCCC_DDDD wstrb=8'h0F over mem=0 -> bresp=00;
//    readback = 64'h0000_0000_CCCC_DDDD.
//  4 Read 0x00001000 and write 0x90000000 (out of range) -> rresp=11 rdata=0; bresp=11, mem unchanged.
//  5 Write len1 with wlast on beat0 -> two beats written, bresp=10; concurrent INCR read completes OKAY.
//  6 Assert rst during beat 2 of len7 read and write bursts -> next cycle rvalid=wready=bvalid=0,
//    arready=awready=1 after release; beats 0-1 of write present in memory.

Source files
------------

// File: rtl/axi_sram_slave.sv
// AXI4-style burst SRAM slave: independent read and write FSMs,
// byte-strobed writes, programmable read latency, DECERR on unmapped space.
module axi_sram_slave #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int DEPTH = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    input  logic [1:0]          arburst,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    output logic                rlast,
    input  logic                rready,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    input  logic [1:0]          awburst,
    input  logic [7:0]          awlen,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int NB = DATA_W / 8;
    localparam int LAT_M1 = (RD_LAT > 0) ? RD_LAT - 1 : 0;
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] lo;
        logic [ADDR_W:0] hi;
        logic [ADDR_W:0] x;
        lo = {1'b0, BASE_ADDR};
        hi = lo + (ADDR_W+1)'(8 * DEPTH);
        x = {1'b0, a};
        return (x >= lo) && (x < hi);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> 3);
    endfunction

    // ---------------- read channel ----------------
    r_state_t          r_state, r_next;
    logic [ADDR_W-1:0] r_addr, r_ld_addr, r_step;
    logic [7:0]        r_len, r_ld_len, r_beat, r_ld_beat;
    logic [2:0]        r_size;
    logic [1:0]        r_burst, r_ld_burst;
    logic [15:0]       r_cnt;
    logic              r_load;

    always_comb begin
        r_next = r_state;
        r_load = 1'b0;
        r_ld_addr = r_addr;
        r_ld_len = r_len;
        r_ld_burst = r_burst;
        r_ld_beat = '0;
        r_step = (r_burst == 2'b00) ? r_addr : r_addr + (ADDR_W'(1) << r_size);
        unique case (r_state)
            R_IDLE: begin
                if (arvalid && arready) begin
                    r_ld_addr = araddr;
                    r_ld_len = arlen;
                    r_ld_burst = arburst;
                    if (RD_LAT == 0) begin
                        r_next = R_DATA;
                        r_load = 1'b1;
                    end else begin
                        r_next = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (r_cnt == 16'(LAT_M1)) begin
                    r_next = R_DATA;
                    r_load = 1'b1;
                end
            end
            R_DATA: begin
                if (rready) begin
                    if (rlast) begin
                        r_next = R_IDLE;
                    end else begin
                        r_load = 1'b1;
                        r_ld_addr = r_step;
                        r_ld_beat = r_beat + 8'd1;
                    end
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid <= 1'b0;
            rlast <= 1'b0;
            rdata <= '0;
            rresp <= OKAY;
            r_addr <= '0;
            r_len <= '0;
            r_size <= '0;
            r_burst <= '0;
            r_beat <= '0;
            r_cnt <= '0;
        end else begin
            r_state <= r_next;
            arready <= (r_next == R_IDLE);
            rvalid <= (r_next == R_DATA);
            r_cnt <= (r_state == R_WAIT) ? r_cnt + 16'd1 : '0;
            if (r_state == R_IDLE && arvalid && arready) begin
                r_addr <= araddr;
                r_len <= arlen;
                r_size <= arsize;
                r_burst <= arburst;
            end
            // Beat payload is captured once and held until the master takes it.
            if (r_load) begin
                r_addr <= r_ld_addr;
                r_beat <= r_ld_beat;
                rlast <= (r_ld_beat == r_ld_len);
                if (in_range(r_ld_addr)) begin
                    rdata <= mem[word_idx(r_ld_addr)];
                    rresp <= r_ld_burst[1] ? SLVERR : OKAY;
                end else begin
                    rdata <= '0;
                    rresp <= DECERR;
                end
            end else if (r_next == R_IDLE) begin
                rlast <= 1'b0;
            end
        end
    end

    // ---------------- write channel ----------------
    w_state_t          w_state, w_next;
    logic [ADDR_W-1:0] w_addr, w_step;
    logic [7:0]        w_len, w_beat;
    logic [1:0]        w_burst, w_err, w_beat_err, w_err_next;
    logic              w_fire, w_end;

    always_comb begin
        w_next = w_state;
        w_fire = (w_state == W_DATA) && wvalid && wready;
        w_end = (w_beat == w_len);
        w_step = (w_burst == 2'b00) ? w_addr : w_addr + ADDR_W'(8);
        if (!in_range(w_addr)) begin
            w_beat_err = DECERR;
        end else if (w_burst[1] || (wlast != w_end)) begin
            w_beat_err = SLVERR;
        end else begin
            w_beat_err = OKAY;
        end
        // Encodings order as severity, so the worst response is a max.
        w_err_next = (w_beat_err > w_err) ? w_beat_err : w_err;
        unique case (w_state)
            W_IDLE: if (awvalid && awready) w_next = W_DATA;
            W_DATA: if (w_fire && w_end) w_next = W_RESP;
            W_RESP: if (bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready <= 1'b0;
            bvalid <= 1'b0;
            bresp <= OKAY;
            w_addr <= '0;
            w_len <= '0;
            w_burst <= '0;
            w_beat <= '0;
            w_err <= OKAY;
        end else begin
            w_state <= w_next;
            awready <= (w_next == W_IDLE);
            wready <= (w_next == W_DATA);
            bvalid <= (w_next == W_RESP);
            if (w_state == W_IDLE && awvalid && awready) begin
                w_addr <= awaddr;
                w_len <= awlen;
                w_burst <= awburst;
                w_beat <= '0;
                w_err <= OKAY;
            end
            if (w_fire) begin
                w_addr <= w_step;
                w_beat <= w_beat + 8'd1;
                w_err <= w_err_next;
                if (w_end) bresp <= w_err_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_fire && in_range(w_addr)) begin
            for (int i = 0; i < NB; i++) begin
                if (wstrb[i]) mem[word_idx(w_addr)][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: reference word model,
// expected beats/responses queued at stimulus time, compared on arrival.
module tb_axi_sram_slave;

    localparam int RD_LAT = 1;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] TOP = 32'h8000_8000;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    logic [31:0] araddr, awaddr;
    logic arvalid, arready, rvalid, rlast, rready;
    logic [1:0] arburst, awburst, rresp, bresp;
    logic [7:0] arlen, awlen, wstrb;
    logic [2:0] arsize;
    logic [63:0] rdata, wdata;
    logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    always #5 clk = ~clk;

    axi_sram_slave #(
        .ADDR_W(32), .DATA_W(64), .DEPTH(4096),
        .BASE_ADDR(BASE), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arburst(arburst),
        .arlen(arlen), .arsize(arsize), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
        .rlast(rlast), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awburst(awburst),
        .awlen(awlen), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    logic [63:0] model [int];
    logic [63:0] wq [$];
    beat_t exp_r [$];
    beat_t got_r [$];
    logic [1:0] exp_b [$];
    int passed = 0;
    int total = 0;
    int lat;
    bit tmo_r, tmo_w, stable;
    logic ar_after;
    logic [1:0] got_b;

    function automatic beat_t exp_beat(input logic [31:0] a, input logic [1:0] burst,
                                       input logic last);
        beat_t b;
        if (a < BASE || a >= TOP) begin
            b.data = 64'h0;
            b.resp = 2'b11;
        end else begin
            b.data = model[int'((a - BASE) >> 3)];
            b.resp = burst[1] ? 2'b10 : 2'b00;
        end
        b.last = last;
        return b;
    endfunction

    task automatic push_read(input logic [31:0] a, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] x;
        x = a;
        for (int i = 0; i <= int'(len); i++) begin
            exp_r.push_back(exp_beat(x, burst, i == int'(len)));
            if (burst != 2'b00) x = x + (32'd1 << size);
        end
    endtask

    task automatic model_wr(input logic [31:0] a, input logic [7:0] len,
                            input logic [1:0] burst, input logic [7:0] strb);
        logic [31:0] x;
        logic [63:0] w;
        int k;
        x = a;
        for (int i = 0; i <= int'(len); i++) begin
            if (x >= BASE && x < TOP) begin
                k = int'((x - BASE) >> 3);
                w = model.exists(k) ? model[k] : 64'h0;
                for (int b = 0; b < 8; b++) if (strb[b]) w[8*b +: 8] = wq[i][8*b +: 8];
                model[k] = w;
            end
            if (burst != 2'b00) x = x + 32'd8;
        end
    endtask

    task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int stall_beat, input int stall_n);
        int n;
        int beat;
        beat_t b;
        logic [63:0] snap;
        @(negedge clk);
        araddr = a; arlen = len; arsize = size; arburst = burst;
        arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        if (!arready) begin tmo_r = 1'b1; arvalid = 1'b0; return; end
        @(negedge clk);
        arvalid = 1'b0;
        lat = 1;
        while (!rvalid && lat < 50) begin @(negedge clk); lat++; end
        beat = 0; n = 0;
        while (beat <= int'(len) && n < 200) begin
            if (rvalid) begin
                if (beat == stall_beat) begin
                    snap = rdata;
                    rready = 1'b0;
                    for (int k = 0; k < stall_n; k++) begin
                        @(negedge clk);
                        if (rdata !== snap || !rvalid) stable = 1'b0;
                    end
                    rready = 1'b1;
                end
                b.data = rdata; b.resp = rresp; b.last = rlast;
                got_r.push_back(b);
                beat++;
            end
            @(negedge clk);
            n++;
        end
        if (beat <= int'(len)) tmo_r = 1'b1;
        ar_after = arready;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                            input logic [7:0] strb, input int wlast_beat);
        int n;
        int beat;
        @(negedge clk);
        awaddr = a; awlen = len; awburst = burst; awvalid = 1'b1; bready = 1'b1;
        n = 0;
        while (!awready && n < 50) begin @(negedge clk); n++; end
        if (!awready) begin tmo_w = 1'b1; awvalid = 1'b0; return; end
        @(negedge clk);
        awvalid = 1'b0;
        beat = 0; n = 0;
        while (beat <= int'(len) && n < 200) begin
            if (wready) begin
                wvalid = 1'b1; wdata = wq.pop_front(); wstrb = strb;
                wlast = (beat == wlast_beat);
                beat++;
            end else begin
                wvalid = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        wvalid = 1'b0; wlast = 1'b0;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        if (!bvalid) tmo_w = 1'b1;
        got_b = bresp;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({arready, awready, wready, rvalid, rlast, bvalid, rdata, rresp, bresp} !== '0)
            $display("FAIL reset_outputs got ar=%b aw=%b w=%b rv=%b rl=%b bv=%b rd=%h rr=%b br=%b req all 0",
                     arready, awready, wready, rvalid, rlast, bvalid, rdata, rresp, bresp);
        else passed++;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({arready, awready} !== 2'b11)
            $display("FAIL reset_release arready/awready got %b%b req 11", arready, awready);
        else passed++;
    endtask

    task automatic test_single_read;
        beat_t e, g;
        logic [1:0] eb;
        wq.push_back(64'h1122334455667788);
        wq.push_back(64'h0102030405060708);
        model_wr(BASE, 8'd1, 2'b01, 8'hFF);
        exp_b.push_back(2'b00);
        do_write(BASE, 8'd1, 2'b01, 8'hFF, 1);
        eb = exp_b.pop_front();
        total++;
        if (got_b !== eb) $display("FAIL single_wr_bresp got %b req %b", got_b, eb);
        else passed++;
        got_r.delete();
        push_read(BASE, 8'd0, 3'd3, 2'b01);
        do_read(BASE, 8'd0, 3'd3, 2'b01, -1, 0);
        total++;
        if (lat !== RD_LAT + 1) $display("FAIL single_rd_latency got %0d req %0d", lat, RD_LAT + 1);
        else passed++;
        while (exp_r.size() > 0) begin
            e = exp_r.pop_front();
            total++;
            if (got_r.size() == 0) $display("FAIL single_rd_beat missing req %h", e.data);
            else begin
                g = got_r.pop_front();
                if (g !== e) $display("FAIL single_rd_beat got %h/%b/%b req %h/%b/%b",
                                      g.data, g.resp, g.last, e.data, e.resp, e.last);
                else passed++;
            end
        end
        total++;
        if (tmo_r || tmo_w) $display("FAIL single_timeout got r=%b w=%b req 0/0", tmo_r, tmo_w);
        else passed++;
    endtask

    task automatic test_burst_read;
        beat_t e, g;
        logic [1:0] eb;
        for (int i = 0; i < 4; i++) wq.push_back(64'hB000_0000_0000_0000 + 64'(i * 64'h1111));
        model_wr(BASE + 32'h10, 8'd3, 2'b01, 8'hFF);
        exp_b.push_back(2'b00);
        do_write(BASE + 32'h10, 8'd3, 2'b01, 8'hFF, 3);
        eb = exp_b.pop_front();
        total++;
        if (got_b !== eb) $display("FAIL burst_wr_bresp got %b req %b", got_b, eb);
        else passed++;
        got_r.delete();
        stable = 1'b1;
        push_read(BASE + 32'h10, 8'd3, 3'd3, 2'b01);
        do_read(BASE + 32'h10, 8'd3, 3'd3, 2'b01, 1, 2);
        while (exp_r.size() > 0) begin
            e = exp_r.pop_front();
            total++;
            if (got_r.size() == 0) $display("FAIL burst_rd_beat missing req %h", e.data);
            else begin
                g = got_r.pop_front();
                if (g !== e) $display("FAIL burst_rd_beat got %h/%b/%b req %h/%b/%b",
                                      g.data, g.resp, g.last, e.data, e.resp, e.last);
                else passed++;
            end
        end
        total++;
        if (stable !== 1'b1) $display("FAIL burst_stall_stable got %b req 1", stable);
        else passed++;
        total++;
        if (ar_after !== 1'b1) $display("FAIL burst_arready_after got %b req 1", ar_after);
        else passed++;
    endtask

    task automatic test_narrow_fixed;
        beat_t e, g;
        got_r.delete();
        push_read(BASE, 8'd2, 3'd2, 2'b01);
        do_read(BASE, 8'd2, 3'd2, 2'b01, -1, 0);
        push_read(BASE + 32'h10, 8'd1, 3'd3, 2'b00);
        do_read(BASE + 32'h10, 8'd1, 3'd3, 2'b00, -1, 0);
        while (exp_r.size() > 0) begin
            e = exp_r.pop_front();
            total++;
            if (got_r.size() == 0) $display("FAIL narrow_fixed_beat missing req %h", e.data);
            else begin
                g = got_r.pop_front();
                if (g !== e) $display("FAIL narrow_fixed_beat got %h/%b/%b req %h/%b/%b",
                                      g.data, g.resp, g.last, e.data, e.resp, e.last);
                else passed++;
            end
        end
    endtask

    task automatic test_strobe_write;
        beat_t g;
        logic [1:0] eb;
        wq.push_back(64'h0);
        model_wr(BASE + 32'h20, 8'd0, 2'b01, 8'hFF);
        exp_b.push_back(2'b00);
        do_write(BASE + 32'h20, 8'd0, 2'b01, 8'hFF, 0);
        wq.push_back(64'hAAAA_BBBB_CCCC_DDDD);
        model_wr(BASE + 32'h20, 8'd0, 2'b01, 8'h0F);
        exp_b.push_back(2'b00);
        do_write(BASE + 32'h20, 8'd0, 2'b01, 8'h0F, 0);
        eb = exp_b.pop_front();
        eb = exp_b.pop_front();
        total++;
        if (got_b !== eb) $display("FAIL strobe_bresp got %b req %b", got_b, eb);
        else passed++;
        got_r.delete();
        exp_r.delete();
        do_read(BASE + 32'h20, 8'd0, 3'd3, 2'b01, -1, 0);
        total++;
        if (got_r.size() == 0) $display("FAIL strobe_readback missing req 00000000ccccdddd");
        else begin
            g = got_r.pop_front();
            if (g.data !== 64'h0000_0000_CCCC_DDDD || g.resp !== 2'b00)
                $display("FAIL strobe_readback got %h/%b req 00000000ccccdddd/00", g.data, g.resp);
            else passed++;
        end
    endtask

    task automatic test_out_of_range;
        beat_t e, g;
        logic [1:0] eb;
        got_r.delete();
        push_read(32'h0000_1000, 8'd0, 3'd3, 2'b01);
        do_read(32'h0000_1000, 8'd0, 3'd3, 2'b01, -1, 0);
        wq.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        model_wr(32'h9000_0000, 8'd0, 2'b01, 8'hFF);
        exp_b.push_back(2'b11);
        do_write(32'h9000_0000, 8'd0, 2'b01, 8'hFF, 0);
        eb = exp_b.pop_front();
        total++;
        if (got_b !== eb) $display("FAIL oor_bresp got %b req %b", got_b, eb);
        else passed++;
        push_read(BASE, 8'd0, 3'd3, 2'b01);
        do_read(BASE, 8'd0, 3'd3, 2'b01, -1, 0);
        push_read(BASE, 8'd1, 3'd3, 2'b10);
        do_read(BASE, 8'd1, 3'd3, 2'b10, -1, 0);
        while (exp_r.size() > 0) begin
            e = exp_r.pop_front();
            total++;
            if (got_r.size() == 0) $display("FAIL oor_rd_beat missing req %h", e.data);
            else begin
                g = got_r.pop_front();
                if (g !== e) $display("FAIL oor_rd_beat got %h/%b/%b req %h/%b/%b",
                                      g.data, g.resp, g.last, e.data, e.resp, e.last);
                else passed++;
            end
        end
    endtask

    task automatic test_wlast_mismatch;
        beat_t e, g;
        logic [1:0] eb;
        got_r.delete();
        wq.push_back(64'h5151_5151_0000_0001);
        wq.push_back(64'h5252_5252_0000_0002);
        model_wr(BASE + 32'h40, 8'd1, 2'b01, 8'hFF);
        exp_b.push_back(2'b10);
        push_read(BASE + 32'h10, 8'd1, 3'd3, 2'b01);
        fork
            do_write(BASE + 32'h40, 8'd1, 2'b01, 8'hFF, 0);
            do_read(BASE + 32'h10, 8'd1, 3'd3, 2'b01, -1, 0);
        join
        eb = exp_b.pop_front();
        total++;
        if (got_b !== eb) $display("FAIL wlast_early_bresp got %b req %b", got_b, eb);
        else passed++;
        wq.push_back(64'h6060_6060_6060_6060);
        model_wr(BASE + 32'h50, 8'd0, 2'b01, 8'hFF);
        exp_b.push_back(2'b10);
        do_write(BASE + 32'h50, 8'd0, 2'b01, 8'hFF, -1);
        eb = exp_b.pop_front();
        total++;
        if (got_b !== eb) $display("FAIL wlast_missing_bresp got %b req %b", got_b, eb);
        else passed++;
        push_read(BASE + 32'h40, 8'd2, 3'd3, 2'b01);
        do_read(BASE + 32'h40, 8'd2, 3'd3, 2'b01, -1, 0);
        while (exp_r.size() > 0) begin
            e = exp_r.pop_front();
            total++;
            if (got_r.size() == 0) $display("FAIL wlast_rd_beat missing req %h", e.data);
            else begin
                g = got_r.pop_front();
                if (g !== e) $display("FAIL wlast_rd_beat got %h/%b/%b req %h/%b/%b",
                                      g.data, g.resp, g.last, e.data, e.resp, e.last);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_mid_burst;
        beat_t e, g;
        logic [31:0] a;
        a = BASE + 32'h100;
        @(negedge clk);
        araddr = a; arlen = 8'd7; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
        awaddr = a; awlen = 8'd7; awburst = 2'b01; awvalid = 1'b1;
        rready = 1'b1; bready = 1'b1;
        @(negedge clk);
        arvalid = 1'b0; awvalid = 1'b0;
        @(negedge clk);
        wvalid = 1'b1; wdata = 64'hD0D0_0000_0000_0000; wstrb = 8'hFF; wlast = 1'b0;
        @(negedge clk);
        wdata = 64'hD1D1_0000_0000_0001;
        @(negedge clk);
        wdata = 64'hD2D2_0000_0000_0002;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({rvalid, wready, bvalid} !== 3'b000)
            $display("FAIL rst_mid_outputs got rv=%b wr=%b bv=%b req 000", rvalid, wready, bvalid);
        else passed++;
        rst = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        total++;
        if ({arready, awready} !== 2'b11)
            $display("FAIL rst_mid_release got ar=%b aw=%b req 11", arready, awready);
        else passed++;
        wq.push_back(64'hD0D0_0000_0000_0000);
        wq.push_back(64'hD1D1_0000_0000_0001);
        model_wr(a, 8'd1, 2'b01, 8'hFF);
        wq.delete();
        got_r.delete();
        push_read(a, 8'd1, 3'd3, 2'b01);
        do_read(a, 8'd1, 3'd3, 2'b01, -1, 0);
        while (exp_r.size() > 0) begin
            e = exp_r.pop_front();
            total++;
            if (got_r.size() == 0) $display("FAIL rst_mid_beat missing req %h", e.data);
            else begin
                g = got_r.pop_front();
                if (g !== e) $display("FAIL rst_mid_beat got %h/%b/%b req %h/%b/%b",
                                      g.data, g.resp, g.last, e.data, e.resp, e.last);
                else passed++;
            end
        end
        total++;
        if (tmo_r || tmo_w) $display("FAIL final_timeout got r=%b w=%b req 0/0", tmo_r, tmo_w);
        else passed++;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired got running req finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        araddr = '0; arvalid = 1'b0; arburst = 2'b01; arlen = '0; arsize = 3'd3;
        rready = 1'b0;
        awaddr = '0; awvalid = 1'b0; awburst = 2'b01; awlen = '0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        tmo_r = 1'b0; tmo_w = 1'b0; stable = 1'b1; lat = 0; ar_after = 1'b0; got_b = 2'b00;
        test_reset();
        test_single_read();
        test_burst_read();
        test_narrow_fixed();
        test_strobe_write();
        test_out_of_range();
        test_wlast_mismatch();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
